// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the timer entry/run controller
package timer_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam digit_t KEY_START_DEF = 4'hA;
    localparam digit_t KEY_STOP_DEF  = 4'hB;
    localparam digit_t KEY_CLEAR_DEF = 4'hC;

    // Codes 0-9 are numeric keys; everything above is a command or unused.
    function automatic logic is_digit(input digit_t code);
        return code <= digit_t'(9);
    endfunction

endpackage

// File: rtl/entry_shift4.sv
// rtl/entry_shift4.sv - four-digit BCD entry shift register (MM:SS)
module entry_shift4
    import timer_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   shift_en,
    input  digit_t shift_in,
    input  logic   clear,
    output digit_t d_m1,
    output digit_t d_m0,
    output digit_t d_s1,
    output digit_t d_s0
);

    // Digits enter at the seconds end and march toward minutes; clear wins over shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_m1 <= '0;
            d_m0 <= '0;
            d_s1 <= '0;
            d_s0 <= '0;
        end else if (clear) begin
            d_m1 <= '0;
            d_m0 <= '0;
            d_s1 <= '0;
            d_s0 <= '0;
        end else if (shift_en) begin
            d_m1 <= d_m0;
            d_m0 <= d_s1;
            d_s1 <= d_s0;
            d_s0 <= shift_in;
        end
    end

endmodule

// File: rtl/timer_entry_ctrl.sv
// rtl/timer_entry_ctrl.sv - keypad entry capture and countdown run control
module timer_entry_ctrl
    import timer_pkg::*;
#(
    parameter digit_t KEY_START = KEY_START_DEF,
    parameter digit_t KEY_STOP  = KEY_STOP_DEF,
    parameter digit_t KEY_CLEAR = KEY_CLEAR_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   key_valid,
    input  digit_t key_code,
    input  logic   tick_1hz,
    input  logic   timer_zero,
    output digit_t digit_m1,
    output digit_t digit_m0,
    output digit_t digit_s1,
    output digit_t digit_s0,
    output logic   load,
    output logic   enable_n,
    output logic   running,
    output logic   done
);

    state_t state;
    state_t state_nxt;
    logic   entry_shift;
    logic   entry_clear;
    logic   entry_nonzero;

    logic key_start;
    logic key_stop;
    logic key_clear;
    logic key_digit;

    assign key_start = key_valid && (key_code == KEY_START);
    assign key_stop  = key_valid && (key_code == KEY_STOP);
    assign key_clear = key_valid && (key_code == KEY_CLEAR);
    // Command codes take precedence in case a parameter is overridden into the 0-9 range.
    assign key_digit = key_valid && is_digit(key_code)
                       && !(key_code == KEY_START)
                       && !(key_code == KEY_STOP)
                       && !(key_code == KEY_CLEAR);

    assign entry_nonzero = |{digit_m1, digit_m0, digit_s1, digit_s0};

    entry_shift4 u_entry (
        .clk      (clk),
        .rst      (rst),
        .shift_en (entry_shift),
        .shift_in (key_code),
        .clear    (entry_clear),
        .d_m1     (digit_m1),
        .d_m0     (digit_m0),
        .d_s1     (digit_s1),
        .d_s0     (digit_s0)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus entry-register control; entry only changes in IDLE or when aborting to IDLE.
    always_comb begin
        state_nxt   = state;
        entry_shift = 1'b0;
        entry_clear = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (key_start) begin
                    if (entry_nonzero) begin
                        state_nxt = ST_LOAD;
                    end
                end else if (key_clear) begin
                    entry_clear = 1'b1;
                end else if (key_digit) begin
                    entry_shift = 1'b1;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Zero detection outranks any key arriving in the same cycle.
                if (timer_zero) begin
                    state_nxt = ST_DONE;
                end else if (key_stop) begin
                    state_nxt = ST_PAUSE;
                end else if (key_clear) begin
                    state_nxt   = ST_IDLE;
                    entry_clear = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (key_start) begin
                    state_nxt = ST_RUN;
                end else if (key_stop || key_clear) begin
                    state_nxt   = ST_IDLE;
                    entry_clear = 1'b1;
                end
            end
            ST_DONE: begin
                if (key_valid) begin
                    state_nxt   = ST_IDLE;
                    entry_clear = 1'b1;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                entry_clear = 1'b1;
            end
        endcase
    end

    // Output decode from the registered state; only enable_n also looks at the live tick.
    always_comb begin
        load     = 1'b0;
        running  = 1'b0;
        done     = 1'b0;
        enable_n = 1'b1;
        unique case (state)
            ST_LOAD: begin
                load    = 1'b1;
                running = 1'b1;
            end
            ST_RUN: begin
                running  = 1'b1;
                enable_n = !tick_1hz;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_timer_entry_ctrl.sv
// tb/tb_timer_entry_ctrl.sv - self-checking bench for timer_entry_ctrl
module tb_timer_entry_ctrl;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       tick_1hz;
    logic       timer_zero;
    logic [3:0] digit_m1, digit_m0, digit_s1, digit_s0;
    logic       load, enable_n, running, done;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [3:0] K_START = 4'hA;
    localparam logic [3:0] K_STOP  = 4'hB;
    localparam logic [3:0] K_CLEAR = 4'hC;

    // Reference model: mode names and a queue of entered digits (index 0 = oldest/m1).
    localparam int M_IDLE = 10, M_LOAD = 11, M_RUN = 12, M_PAUSE = 13, M_DONE = 14;
    int m_mode;
    int m_dig[$];

    // Snapshots taken mid-cycle: {m1,m0,s1,s0,load,enable_n,running,done}.
    logic [19:0] s_obs;
    logic [19:0] s_exp;

    timer_entry_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .tick_1hz   (tick_1hz),
        .timer_zero (timer_zero),
        .digit_m1   (digit_m1),
        .digit_m0   (digit_m0),
        .digit_s1   (digit_s1),
        .digit_s0   (digit_s0),
        .load       (load),
        .enable_n   (enable_n),
        .running    (running),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] dut_vec();
        return {digit_m1, digit_m0, digit_s1, digit_s0, load, enable_n, running, done};
    endfunction

    function automatic logic [19:0] model_vec(input logic tk);
        logic [15:0] d;
        d = {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3])};
        return {d, (m_mode == M_LOAD), !(m_mode == M_RUN && tk),
                (m_mode == M_LOAD || m_mode == M_RUN), (m_mode == M_DONE)};
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_dig  = '{0, 0, 0, 0};
    endfunction

    function automatic void model_step(input logic kv, input logic [3:0] kc, input logic tz);
        int total;
        total = m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3];
        case (m_mode)
            M_IDLE: if (kv) begin
                if (kc == K_START) begin
                    if (total != 0) m_mode = M_LOAD;
                end else if (kc == K_CLEAR) begin
                    m_dig = '{0, 0, 0, 0};
                end else if (kc <= 4'd9) begin
                    void'(m_dig.pop_front());
                    m_dig.push_back(int'(kc));
                end
            end
            M_LOAD: m_mode = M_RUN;
            M_RUN: begin
                if (tz) m_mode = M_DONE;
                else if (kv && kc == K_STOP) m_mode = M_PAUSE;
                else if (kv && kc == K_CLEAR) begin
                    m_mode = M_IDLE;
                    m_dig  = '{0, 0, 0, 0};
                end
            end
            M_PAUSE: if (kv) begin
                if (kc == K_START) m_mode = M_RUN;
                else if (kc == K_STOP || kc == K_CLEAR) begin
                    m_mode = M_IDLE;
                    m_dig  = '{0, 0, 0, 0};
                end
            end
            M_DONE: if (kv) begin
                m_mode = M_IDLE;
                m_dig  = '{0, 0, 0, 0};
            end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    // One clock cycle: drive, snapshot DUT and model at the falling edge, advance at the rising edge.
    task automatic cyc(input logic kv, input logic [3:0] kc, input logic tk, input logic tz);
        key_valid  = kv;
        key_code   = kc;
        tick_1hz   = tk;
        timer_zero = tz;
        @(negedge clk);
        s_obs = dut_vec();
        s_exp = model_vec(tk);
        @(posedge clk);
        model_step(kv, kc, tz);
        #1;
        key_valid  = 1'b0;
        tick_1hz   = 1'b0;
        timer_zero = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_valid = 1'b0; key_code = 4'h0; tick_1hz = 1'b1; timer_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec() !== 20'h00004) begin
            n_errors++;
            $display("FAIL reset_values: got %h expected %h", dut_vec(), 20'h00004);
        end
        rst = 1'b0;
        tick_1hz = 1'b0;
        model_reset();
    endtask

    task automatic test_entry_start();
        logic [3:0] keys [4];
        keys = '{4'd1, 4'd2, 4'd3, 4'd0};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, keys[i], 1'b0, 1'b0);
            n_checks++;
            if (s_obs !== s_exp) begin
                n_errors++;
                $display("FAIL entry_key%0d: got %h expected %h", i, s_obs, s_exp);
            end
        end
        cyc(1'b1, K_START, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        n_checks++;
        if (s_obs !== {16'h1230, 4'b1110} || s_obs !== s_exp) begin
            n_errors++;
            $display("FAIL start_load_pulse: got %h expected %h", s_obs, {16'h1230, 4'b1110});
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        n_checks++;
        if (s_obs !== {16'h1230, 4'b0110} || s_obs !== s_exp) begin
            n_errors++;
            $display("FAIL load_one_cycle: got %h expected %h", s_obs, {16'h1230, 4'b0110});
        end
        cyc(1'b1, K_CLEAR, 1'b0, 1'b0);
    endtask

    task automatic test_shift_clear();
        logic [3:0] seq [8];
        seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'hF, K_STOP, K_CLEAR};
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, seq[i], 1'b0, 1'b0);
            n_checks++;
            if (s_obs !== s_exp) begin
                n_errors++;
                $display("FAIL shift_step%0d: got %h expected %h", i, s_obs, s_exp);
            end
            if (i == 6) begin
                n_checks++;
                if (s_obs[19:4] !== 16'h2345) begin
                    n_errors++;
                    $display("FAIL oldest_dropped: got %h expected 2345", s_obs[19:4]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, K_START, 1'b0, 1'b0);
            n_checks++;
            if (s_obs !== {16'h0000, 4'b0100} || s_obs !== s_exp) begin
                n_errors++;
                $display("FAIL start_on_zero%0d: got %h expected %h", i, s_obs, {16'h0000, 4'b0100});
            end
        end
    endtask

    task automatic test_pause_resume();
        int loads = 0;
        cyc(1'b1, 4'd1, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 1'b0, 1'b0);
        cyc(1'b1, K_START, 1'b0, 1'b0);
        for (int c = 0; c < 90; c++) begin
            logic kv;
            logic [3:0] kc;
            kv = 1'b0; kc = 4'h0;
            if (c == 30) begin kv = 1'b1; kc = K_STOP; end
            if (c == 60) begin kv = 1'b1; kc = K_START; end
            cyc(kv, kc, (c % 10) == 9, 1'b0);
            if (c > 0 && s_obs[3]) loads++;
            n_checks++;
            if (s_obs !== s_exp) begin
                n_errors++;
                $display("FAIL pause_cycle%0d: got %h expected %h", c, s_obs, s_exp);
            end
            if (c == 39 || c == 49 || c == 59) begin
                n_checks++;
                if (s_obs[2] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL paused_tick_gated%0d: got %b expected 1", c, s_obs[2]);
                end
            end
        end
        n_checks++;
        if (loads !== 0) begin
            n_errors++;
            $display("FAIL resume_no_reload: got %0d load pulses expected 0", loads);
        end
        cyc(1'b1, K_STOP, 1'b0, 1'b0);
        cyc(1'b1, K_CLEAR, 1'b0, 1'b0);
    endtask

    task automatic test_zero_priority();
        cyc(1'b1, 4'd7, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 1'b0, 1'b0);
        cyc(1'b1, K_START, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        cyc(1'b1, K_CLEAR, 1'b1, 1'b1);
        n_checks++;
        if (s_obs !== {16'h0075, 4'b0010} || s_obs !== s_exp) begin
            n_errors++;
            $display("FAIL zero_with_clear_cycle: got %h expected %h", s_obs, {16'h0075, 4'b0010});
        end
        cyc(1'b0, 4'h0, 1'b1, 1'b1);
        n_checks++;
        if (s_obs !== {16'h0075, 4'b0101} || s_obs !== s_exp) begin
            n_errors++;
            $display("FAIL done_state: got %h expected %h", s_obs, {16'h0075, 4'b0101});
        end
        cyc(1'b1, 4'd3, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        n_checks++;
        if (s_obs !== {16'h0000, 4'b0100} || s_obs !== s_exp) begin
            n_errors++;
            $display("FAIL done_key_to_idle: got %h expected %h", s_obs, {16'h0000, 4'b0100});
        end
    endtask

    task automatic test_stop_tick();
        cyc(1'b1, 4'd9, 1'b0, 1'b0);
        cyc(1'b1, K_START, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b1, K_STOP, 1'b1, 1'b0);
        n_checks++;
        if (s_obs[2] !== 1'b0 || s_obs !== s_exp) begin
            n_errors++;
            $display("FAIL stop_with_tick_decrements: got %h expected %h", s_obs, s_exp);
        end
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        n_checks++;
        if (s_obs !== {16'h0009, 4'b0100} || s_obs !== s_exp) begin
            n_errors++;
            $display("FAIL stop_then_pause: got %h expected %h", s_obs, {16'h0009, 4'b0100});
        end
        cyc(1'b1, K_CLEAR, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            logic kv, tk, tz;
            logic [3:0] kc;
            kv = ($urandom_range(0, 2) == 0);
            kc = 4'($urandom_range(0, 15));
            tk = ($urandom_range(0, 4) == 0);
            tz = ($urandom_range(0, 9) == 0);
            cyc(kv, kc, tk, tz);
            n_checks++;
            if (s_obs !== s_exp) begin
                n_errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", c, s_obs, s_exp);
            end
        end
    endtask

    task automatic test_async_reset();
        cyc(1'b1, K_CLEAR, 1'b0, 1'b0);
        cyc(1'b1, 4'd4, 1'b0, 1'b0);
        cyc(1'b1, K_START, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        tick_1hz = 1'b1;
        #2;
        n_checks++;
        if (dut_vec() !== {16'h0004, 4'b0010}) begin
            n_errors++;
            $display("FAIL pre_reset_run: got %h expected %h", dut_vec(), {16'h0004, 4'b0010});
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (dut_vec() !== 20'h00004) begin
            n_errors++;
            $display("FAIL async_reset: got %h expected %h", dut_vec(), 20'h00004);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick_1hz = 1'b0;
        model_reset();
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        n_checks++;
        if (s_obs !== s_exp) begin
            n_errors++;
            $display("FAIL post_reset_idle: got %h expected %h", s_obs, s_exp);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_entry_start();
        test_shift_clear();
        test_pause_resume();
        test_zero_priority();
        test_stop_tick();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer_entry_ctrl.md
# timer_entry_ctrl

Keypad entry and run-control stage for the microwave countdown timer. Sits directly upstream of the MM:SS down-counter chain. Captures four BCD digits typed on the keypad. On start, issues a one-cycle parallel load into the counters, then gates their count enable with the 1 Hz tick until the chain reports zero, the user pauses, or the user clears.

## Interface
Parameters:
- KEY_START, 4'hA, key code that starts or resumes the countdown
- KEY_STOP, 4'hB, key code that pauses the countdown
- KEY_CLEAR, 4'hC, key code that clears the entry or aborts the countdown

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle strobe: key_code is valid this cycle
- key_code  in  4  0–9 are digits; KEY_START, KEY_STOP, KEY_CLEAR are commands; all other codes are ignored
- tick_1hz  in  1  one-cycle pulse, once per second
- timer_zero  in  1  high when all four counter digits read 00:00
- digit_m1, digit_m0, digit_s1, digit_s0  out  4 each  entered BCD digits (MM:SS) presented to the counter load inputs
- load  out  1  one-cycle parallel-load pulse to the counter chain
- enable_n  out  1  active-low count enable to the counter chain
- running  out  1  high in LOAD and RUN
- done  out  1  high while in DONE

## Operation
- FSM states: IDLE, LOAD, RUN, PAUSE, DONE.
- IDLE (entry mode):
  - A digit key shifts the entry left: m1←m0, m0←s1, s1←s0, s0←key. The oldest digit is discarded.
  - KEY_CLEAR zeroes all four digits.
  - KEY_START with a nonzero entry → LOAD. KEY_START with entry 00:00 is ignored.
  - KEY_STOP is ignored.
- LOAD: load=1 for exactly one cycle, then → RUN unconditionally. Keys arriving in LOAD are dropped.
- RUN:
  - timer_zero=1 → DONE.
  - KEY_STOP → PAUSE.
  - KEY_CLEAR → IDLE with the entry zeroed.
  - Digit keys and KEY_START are ignored.
- PAUSE:
  - KEY_START → RUN. No reload; the counters keep their value.
  - KEY_STOP or KEY_CLEAR → IDLE with the entry zeroed.
- DONE: any key_valid → IDLE with the entry zeroed. The key itself is consumed, not applied.
- No range check on digits: seconds entries 60–99 are legal and are loaded as-is. The counter chain counts down from that value.
- Entry digits are held constant outside IDLE, so the load inputs stay stable during LOAD.

## Timing
- Reset values (async on rst rise, held while rst=1):
  - state=IDLE
  - all digits 4'h0
  - load=0, enable_n=1, running=0, done=0
- enable_n is combinational: 0 only when state==RUN and tick_1hz=1; otherwise 1. It is never 0 in LOAD, PAUSE, DONE or IDLE.
- load, running and done are decoded from the registered state, so they are glitch-free at the clock edge.
- Latencies:
  - key_valid(START) at edge N → load=1 during cycle N+1.
  - First possible enable_n=0 is at cycle N+2.
- timer_zero is evaluated only in RUN. It is ignored in LOAD because the counters have not yet reloaded.
- Simultaneous events in RUN:
  - timer_zero and a key in the same cycle: timer_zero wins (→ DONE) and the key is dropped.
  - KEY_STOP and tick_1hz in the same cycle: the decrement occurs (enable_n=0 that cycle), then PAUSE.
- Only one key is accepted per cycle. key_valid pulses longer than one cycle are treated as repeated keys.
- rst mid-RUN: immediate return to IDLE with enable_n=1. The counter chain has its own reset.

## Structure
- Shared package timer_pkg holds:
  - the state encoding (IDLE=3'd0, LOAD=3'd1, RUN=3'd2, PAUSE=3'd3, DONE=3'd4)
  - default key-code constants
  - the BCD digit width (4)
- One sub-module: entry_shift4, the four-digit BCD shift register with shift-in, synchronous clear and async reset.
- The FSM and output decode live in timer_entry_ctrl.

## Test plan
- Keys 1,2,3,0 then START → digits 1,2,3,0 (12:30); load high for exactly 1 cycle, 1 cycle after the START strobe; running=1.
- Keys 1,2,3,4,5 → digits 2,3,4,5 (oldest dropped); CLEAR → 00:00; START on 00:00 → stays IDLE, load never asserts.
- RUN with tick_1hz every 10 cycles → enable_n low only on tick cycles; STOP → PAUSE with enable_n=1 on later ticks; START → RUN with no load pulse.
- Entry 00:75, START, then drive timer_zero=1 with KEY_CLEAR in the same cycle → DONE, done=1; the next key → IDLE with digits 0.
- STOP coinciding with tick in RUN → enable_n=0 that cycle, state=PAUSE next cycle.
- Assert rst during RUN → all outputs at reset values immediately (asynchronously), state=IDLE, digits 0.
